// File: rtl/rf_ctrl_pkg.sv
// Shared encodings and widths for the register-file write-port arbiter.
package rf_ctrl_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned WE_W     = 4;

  localparam logic [WE_W-1:0] RF_WE_ALL  = 4'b1111;
  localparam logic [WE_W-1:0] RF_WE_NONE = 4'b0000;

  localparam logic [1:0] NORMAL = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] FORCE  = 2'd2;

  typedef enum logic [1:0] {
    ST_NORMAL = NORMAL,
    ST_WAIT   = WAIT,
    ST_FORCE  = FORCE
  } arb_state_e;

  // One register-file write: destination and data.
  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
  } rf_wr_t;

  // One-hot mask selecting register a.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register with an
// outstanding long-latency result, looked up by the two decode read ports.
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_i,
  input  logic [REG_AW-1:0] set_wa_i,
  input  logic              clr_i,
  input  logic [REG_AW-1:0] clr_wa_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Next pending vector; a set on the same register as a clear wins, $0 never marked.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    if (set_i && (set_wa_i != '0)) set_mask = reg_onehot(set_wa_i);
    if (clr_i)                     clr_mask = reg_onehot(clr_wa_i);
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // Pending vector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // Lookups come from the registered vector only (no same-cycle bypass).
  assign busy1_o = (ra1_i != '0) && pending_q[ra1_i];
  assign busy2_o = (ra2_i != '0) && pending_q[ra2_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB pipeline has priority, a starvation
// FSM forces a pipeline stall so the long-latency unit eventually writes.
// rst_ni is asynchronous, active-low.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pipe_we_i,
  input  logic [REG_AW-1:0] pipe_wa_i,
  input  logic [DATA_W-1:0] pipe_wd_i,
  input  logic              lu_valid_i,
  input  logic [REG_AW-1:0] lu_wa_i,
  input  logic [DATA_W-1:0] lu_wd_i,
  output logic              lu_ready_o,
  input  logic              iss_valid_i,
  input  logic [REG_AW-1:0] iss_wa_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic              stall_pipe_o,
  output logic [WE_W-1:0]   rf_we_o,
  output logic [REG_AW-1:0] rf_wa_o,
  output logic [DATA_W-1:0] rf_wd_o
);

  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [WE_W-1:0]   rf_we_q;
  logic [REG_AW-1:0] rf_wa_q;
  logic [DATA_W-1:0] rf_wd_q;

  logic              lu_rdy;
  logic              pipe_take;
  logic              lu_take;
  logic              lu_blocked;
  rf_wr_t            win;
  logic [WE_W-1:0]   rf_we_d;

  // Priority select: pipeline first except in FORCE, where only the lu may write.
  always_comb begin
    lu_rdy    = 1'b0;
    pipe_take = 1'b0;
    lu_take   = 1'b0;
    win       = '0;
    rf_we_d   = RF_WE_NONE;
    if (state_q == ST_FORCE) begin
      lu_rdy = 1'b1;
    end else begin
      lu_rdy    = !pipe_we_i;
      pipe_take = pipe_we_i;
    end
    lu_take = lu_valid_i && lu_rdy;
    if (pipe_take) begin
      win.wa = pipe_wa_i;
      win.wd = pipe_wd_i;
    end else if (lu_take) begin
      win.wa = lu_wa_i;
      win.wd = lu_wd_i;
    end
    if ((pipe_take || lu_take) && (win.wa != '0)) rf_we_d = RF_WE_ALL;
  end

  assign lu_blocked = lu_valid_i && pipe_we_i;

  // Starvation FSM and blocked-cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_NORMAL: begin
          if (lu_blocked) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!lu_valid_i || lu_take) begin
            state_q    <= ST_NORMAL;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == LIMIT_CNT) begin
            state_q    <= ST_FORCE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        ST_FORCE: begin
          // lu_valid is held until accepted and lu_ready is 1 here, so one cycle suffices.
          state_q    <= ST_NORMAL;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= ST_NORMAL;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Write-port output registers; address/data only reload on a grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q <= RF_WE_NONE;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      if (pipe_take || lu_take) begin
        rf_wa_q <= win.wa;
        rf_wd_q <= win.wd;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .set_i    (iss_valid_i),
    .set_wa_i (iss_wa_i),
    .clr_i    (lu_take),
    .clr_wa_i (lu_wa_i),
    .ra1_i    (ra1_i),
    .ra2_i    (ra2_i),
    .busy1_o  (busy1_o),
    .busy2_o  (busy2_o)
  );

  assign lu_ready_o   = lu_rdy;
  assign stall_pipe_o = (state_q == ST_FORCE);
  assign rf_we_o      = rf_we_q;
  assign rf_wa_o      = rf_wa_q;
  assign rf_wd_o      = rf_wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a STARVE_LIMIT=4 instance fully
// checked, plus a STARVE_LIMIT=1 instance whose stall timing is checked.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
  import rf_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we, lu_valid, iss_valid;
  logic [4:0]  pipe_wa, lu_wa, iss_wa, ra1, ra2;
  logic [31:0] pipe_wd, lu_wd;

  logic        lu_ready_o, busy1_o, busy2_o, stall_pipe_o;
  logic [3:0]  rf_we_o;
  logic [4:0]  rf_wa_o;
  logic [31:0] rf_wd_o;

  logic        u1_lu_ready, u1_busy1, u1_busy2, u1_stall;
  logic [3:0]  u1_rf_we;
  logic [4:0]  u1_rf_wa;
  logic [31:0] u1_rf_wd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic pwe; logic [4:0] pwa; logic [31:0] pwd;
    logic lv;  logic [4:0] lwa; logic [31:0] lwd;
    logic iv;  logic [4:0] iwa;
    logic [4:0] ra1; logic [4:0] ra2;
    logic e_rdy; logic e_stall; logic e_st1;
    logic e_b1;  logic e_b2;
    logic e_we;  logic [4:0] e_wa; logic [31:0] e_wd;
  } row_t;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pipe_we_i(pipe_we), .pipe_wa_i(pipe_wa), .pipe_wd_i(pipe_wd),
    .lu_valid_i(lu_valid), .lu_wa_i(lu_wa), .lu_wd_i(lu_wd), .lu_ready_o(lu_ready_o),
    .iss_valid_i(iss_valid), .iss_wa_i(iss_wa),
    .ra1_i(ra1), .ra2_i(ra2), .busy1_o(busy1_o), .busy2_o(busy2_o),
    .stall_pipe_o(stall_pipe_o),
    .rf_we_o(rf_we_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o)
  );

  rf_wb_arbiter #(.STARVE_LIMIT(1), .CNT_W(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .pipe_we_i(pipe_we), .pipe_wa_i(pipe_wa), .pipe_wd_i(pipe_wd),
    .lu_valid_i(lu_valid), .lu_wa_i(lu_wa), .lu_wd_i(lu_wd), .lu_ready_o(u1_lu_ready),
    .iss_valid_i(iss_valid), .iss_wa_i(iss_wa),
    .ra1_i(ra1), .ra2_i(ra2), .busy1_o(u1_busy1), .busy2_o(u1_busy2),
    .stall_pipe_o(u1_stall),
    .rf_we_o(u1_rf_we), .rf_wa_o(u1_rf_wa), .rf_wd_o(u1_rf_wd)
  );

  function automatic row_t mkrow(input int pwe, input int pwa, input int pwd,
                                 input int lv, input int lwa, input int lwd,
                                 input int iv, input int iwa, input int a1, input int a2,
                                 input int rdy, input int st, input int st1,
                                 input int b1, input int b2,
                                 input int we, input int wa, input int wd);
    row_t r;
    r.pwe = 1'(pwe); r.pwa = 5'(pwa); r.pwd = 32'(pwd);
    r.lv  = 1'(lv);  r.lwa = 5'(lwa); r.lwd = 32'(lwd);
    r.iv  = 1'(iv);  r.iwa = 5'(iwa);
    r.ra1 = 5'(a1);  r.ra2 = 5'(a2);
    r.e_rdy = 1'(rdy); r.e_stall = 1'(st); r.e_st1 = 1'(st1);
    r.e_b1 = 1'(b1); r.e_b2 = 1'(b2);
    r.e_we = 1'(we); r.e_wa = 5'(wa); r.e_wd = 32'(wd);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
    lu_valid = 1'b0; lu_wa = '0; lu_wd = '0;
    iss_valid = 1'b0; iss_wa = '0; ra1 = '0; ra2 = '0;
  endtask

  // Drives one row and records the rf write expected on the next cycle.
  task automatic apply_row(input row_t r);
    exp_t e;
    pipe_we = r.pwe; pipe_wa = r.pwa; pipe_wd = r.pwd;
    lu_valid = r.lv; lu_wa = r.lwa; lu_wd = r.lwd;
    iss_valid = r.iv; iss_wa = r.iwa; ra1 = r.ra1; ra2 = r.ra2;
    e.we = r.e_we ? RF_WE_ALL : RF_WE_NONE;
    e.wa = r.e_wa;
    e.wd = r.e_wd;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (rf_we_o !== 4'b0000 || rf_wa_o !== 5'd0 || rf_wd_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rf: got we=%b wa=%0d wd=%h, want 0000/0/0", rf_we_o, rf_wa_o, rf_wd_o);
    end
    n_checks++;
    if (stall_pipe_o !== 1'b0 || busy1_o !== 1'b0 || busy2_o !== 1'b0 || lu_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctl: got stall=%b busy=%b%b rdy=%b, want 0 00 1",
               stall_pipe_o, busy1_o, busy2_o, lu_ready_o);
    end
    n_checks++;
    if (u1_stall !== 1'b0 || u1_rf_we !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_u1: got stall=%b we=%b, want 0 0000", u1_stall, u1_rf_we);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pipe_lu();
    row_t rows[$];
    exp_t e;
    rows.push_back(mkrow(1,5,32'hDEADBEEF, 0,0,0,            0,0, 0,0, 0,0,0, 0,0, 1,5,32'hDEADBEEF));
    rows.push_back(mkrow(0,0,0,            1,7,32'h11,        0,0, 0,0, 1,0,0, 0,0, 1,7,32'h11));
    rows.push_back(mkrow(1,3,32'h12345678, 0,0,0,            0,0, 0,0, 0,0,0, 0,0, 1,3,32'h12345678));
    rows.push_back(mkrow(1,31,32'hFFFFFFFF,0,0,0,            0,0, 0,0, 0,0,0, 0,0, 1,31,32'hFFFFFFFF));
    rows.push_back(mkrow(1,0,32'hCAFE,     0,0,0,            0,0, 0,0, 0,0,0, 0,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,            1,0,32'h55,        0,0, 0,0, 1,0,0, 0,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,            0,0,0,            0,0, 0,0, 1,0,0, 0,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,            1,4,32'hA5A5A5A5,  0,0, 0,0, 1,0,0, 0,0, 1,4,32'hA5A5A5A5));
    rows.push_back(mkrow(0,0,0,            0,0,0,            0,0, 0,0, 1,0,0, 0,0, 0,0,0));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      #1;
      n_checks++;
      if (lu_ready_o !== rows[i].e_rdy || stall_pipe_o !== rows[i].e_stall) begin
        n_fail++;
        $display("FAIL pipe_lu_ctl row %0d: got rdy=%b stall=%b, want %b %b",
                 i, lu_ready_o, stall_pipe_o, rows[i].e_rdy, rows[i].e_stall);
      end
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pipe_lu_rf row %0d: no expected entry", i);
      end else begin
        e = exp_q.pop_front();
        if (rf_we_o !== e.we || (e.we == RF_WE_ALL && (rf_wa_o !== e.wa || rf_wd_o !== e.wd))) begin
          n_fail++;
          $display("FAIL pipe_lu_rf row %0d: got we=%b wa=%0d wd=%h, want we=%b wa=%0d wd=%h",
                   i, rf_we_o, rf_wa_o, rf_wd_o, e.we, e.wa, e.wd);
        end
      end
    end
  endtask

  task automatic test_starve();
    row_t rows[$];
    exp_t e;
    // Held lu request against a continuous pipeline: FORCE on the 6th cycle (limit 4).
    for (int k = 0; k < 5; k++)
      rows.push_back(mkrow(1,16+k,32'h100+k, 1,12,32'hABCD, 0,0, 0,0, 0,0,(k==2)?1:0, 0,0, 1,16+k,32'h100+k));
    rows.push_back(mkrow(1,21,32'h105, 1,12,32'hABCD, 0,0, 0,0, 1,1,1, 0,0, 1,12,32'hABCD));
    rows.push_back(mkrow(1,21,32'h105, 0,0,0,         0,0, 0,0, 0,0,0, 0,0, 1,21,32'h105));
    rows.push_back(mkrow(0,0,0,        0,0,0,         0,0, 0,0, 1,0,0, 0,0, 0,0,0));
    // lu drops once while waiting, which restarts the count.
    for (int b = 0; b < 7; b++)
      rows.push_back(mkrow(1,24+b,32'h200+b, (b==1)?0:1,13,32'hBEEF, 0,0, 0,0,
                           0,0,(b==4)?1:0, 0,0, 1,24+b,32'h200+b));
    rows.push_back(mkrow(1,31,32'h207, 1,13,32'hBEEF, 0,0, 0,0, 1,1,1, 0,0, 1,13,32'hBEEF));
    rows.push_back(mkrow(1,31,32'h207, 0,0,0,         0,0, 0,0, 0,0,0, 0,0, 1,31,32'h207));
    rows.push_back(mkrow(0,0,0,        0,0,0,         0,0, 0,0, 1,0,0, 0,0, 0,0,0));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      #1;
      n_checks++;
      if (lu_ready_o !== rows[i].e_rdy || stall_pipe_o !== rows[i].e_stall) begin
        n_fail++;
        $display("FAIL starve_ctl row %0d: got rdy=%b stall=%b, want %b %b",
                 i, lu_ready_o, stall_pipe_o, rows[i].e_rdy, rows[i].e_stall);
      end
      n_checks++;
      if (u1_stall !== rows[i].e_st1) begin
        n_fail++;
        $display("FAIL starve_limit1 row %0d: got stall=%b, want %b", i, u1_stall, rows[i].e_st1);
      end
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL starve_rf row %0d: no expected entry", i);
      end else begin
        e = exp_q.pop_front();
        if (rf_we_o !== e.we || (e.we == RF_WE_ALL && (rf_wa_o !== e.wa || rf_wd_o !== e.wd))) begin
          n_fail++;
          $display("FAIL starve_rf row %0d: got we=%b wa=%0d wd=%h, want we=%b wa=%0d wd=%h",
                   i, rf_we_o, rf_wa_o, rf_wd_o, e.we, e.wa, e.wd);
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    row_t rows[$];
    exp_t e;
    rows.push_back(mkrow(0,0,0,         0,0,0,          1,9,  9,0,  1,0,0, 0,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,         0,0,0,          0,0,  9,0,  1,0,0, 1,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,         1,9,32'h99,     0,0,  9,0,  1,0,0, 1,0, 1,9,32'h99));
    rows.push_back(mkrow(0,0,0,         0,0,0,          0,0,  9,0,  1,0,0, 0,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,         0,0,0,          1,9,  9,0,  1,0,0, 0,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,         1,9,32'h77,     1,9,  9,0,  1,0,0, 1,0, 1,9,32'h77));
    rows.push_back(mkrow(0,0,0,         0,0,0,          0,0,  9,0,  1,0,0, 1,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,         0,0,0,          1,20, 9,20, 1,0,0, 1,0, 0,0,0));
    rows.push_back(mkrow(1,20,32'h3030, 0,0,0,          0,0,  20,20,0,0,0, 1,1, 1,20,32'h3030));
    rows.push_back(mkrow(1,21,32'h3131, 1,20,32'h4040,  0,0,  0,20, 0,0,0, 0,1, 1,21,32'h3131));
    rows.push_back(mkrow(0,0,0,         1,20,32'h4040,  0,0,  9,20, 1,0,0, 1,1, 1,20,32'h4040));
    rows.push_back(mkrow(0,0,0,         1,9,32'h9999,   0,0,  9,20, 1,0,0, 1,0, 1,9,32'h9999));
    rows.push_back(mkrow(0,0,0,         0,0,0,          1,0,  9,0,  1,0,0, 0,0, 0,0,0));
    rows.push_back(mkrow(0,0,0,         0,0,0,          0,0,  0,0,  1,0,0, 0,0, 0,0,0));
    foreach (rows[i]) begin
      apply_row(rows[i]);
      #1;
      n_checks++;
      if (busy1_o !== rows[i].e_b1 || busy2_o !== rows[i].e_b2 || lu_ready_o !== rows[i].e_rdy) begin
        n_fail++;
        $display("FAIL sb_busy row %0d: got busy1=%b busy2=%b rdy=%b, want %b %b %b",
                 i, busy1_o, busy2_o, lu_ready_o, rows[i].e_b1, rows[i].e_b2, rows[i].e_rdy);
      end
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_rf row %0d: no expected entry", i);
      end else begin
        e = exp_q.pop_front();
        if (rf_we_o !== e.we || (e.we == RF_WE_ALL && (rf_wa_o !== e.wa || rf_wd_o !== e.wd))) begin
          n_fail++;
          $display("FAIL sb_rf row %0d: got we=%b wa=%0d wd=%h, want we=%b wa=%0d wd=%h",
                   i, rf_we_o, rf_wa_o, rf_wd_o, e.we, e.wa, e.wd);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    set_idle();
    pipe_we = 1'b1; pipe_wa = 5'd1; pipe_wd = 32'h5A5A5A5A;
    lu_valid = 1'b1; lu_wa = 5'd8; lu_wd = 32'h88;
    iss_valid = 1'b1; iss_wa = 5'd6; ra1 = 5'd6; ra2 = 5'd6;
    tick();
    iss_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (stall_pipe_o !== 1'b1 || busy1_o !== 1'b1 || rf_we_o !== RF_WE_ALL) begin
      n_fail++;
      $display("FAIL arst_pre: got stall=%b busy1=%b we=%b, want 1 1 1111", stall_pipe_o, busy1_o, rf_we_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rf_we_o !== 4'b0000 || rf_wa_o !== 5'd0 || rf_wd_o !== 32'd0) begin
      n_fail++;
      $display("FAIL arst_rf: got we=%b wa=%0d wd=%h, want 0000/0/0", rf_we_o, rf_wa_o, rf_wd_o);
    end
    n_checks++;
    if (stall_pipe_o !== 1'b0 || busy1_o !== 1'b0 || busy2_o !== 1'b0 || lu_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_ctl: got stall=%b busy=%b%b rdy=%b, want 0 00 0",
               stall_pipe_o, busy1_o, busy2_o, lu_ready_o);
    end
    set_idle();
    ra1 = 5'd6;
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (rf_we_o !== 4'b0000 || busy1_o !== 1'b0 || stall_pipe_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_after: got we=%b busy1=%b stall=%b, want 0000 0 0", rf_we_o, busy1_o, stall_pipe_o);
    end
  endtask

  initial begin
    test_reset();
    test_pipe_lu();
    test_starve();
    test_scoreboard();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
